// File: rtl/bob_except_scan_if.sv
// Retire request, exception-RAM read port and retire result bundle for
// bob_except_scan. The requester/RAM side is the master; the scanner is the slave.
interface bob_except_scan_if #(
   parameter int DATA_WIDTH = 12
);
   // retire request
   logic                  ret_valid;
   logic                  ret_ready;
   logic [5:0]            ret_bndl;
   logic [9:0]            ret_mask;

   // exception record RAM read port
   logic                  read_step;
   logic [5:0]            read_addr;
   logic [DATA_WIDTH-1:0] read_data0;
   logic [DATA_WIDTH-1:0] read_data1;
   logic [DATA_WIDTH-1:0] read_data2;
   logic [DATA_WIDTH-1:0] read_data3;
   logic [DATA_WIDTH-1:0] read_data4;
   logic [DATA_WIDTH-1:0] read_data5;
   logic [DATA_WIDTH-1:0] read_data6;
   logic [DATA_WIDTH-1:0] read_data7;
   logic [DATA_WIDTH-1:0] read_data8;
   logic [DATA_WIDTH-1:0] read_data9;

   // per-bundle result
   logic                  res_valid;
   logic                  res_ready;
   logic [5:0]            res_bndl;
   logic                  res_excpt;
   logic [3:0]            res_slot;
   logic [4:0]            res_code;
   logic [DATA_WIDTH-8:0] res_aux;
   logic [3:0]            res_count;
   logic [7:0]            poll_cnt;

   modport slave (
      input  ret_valid, ret_bndl, ret_mask,
      input  read_data0, read_data1, read_data2, read_data3, read_data4,
      input  read_data5, read_data6, read_data7, read_data8, read_data9,
      input  res_ready,
      output ret_ready, read_step, read_addr,
      output res_valid, res_bndl, res_excpt, res_slot, res_code, res_aux,
      output res_count, poll_cnt
   );

   modport master (
      output ret_valid, ret_bndl, ret_mask,
      output read_data0, read_data1, read_data2, read_data3, read_data4,
      output read_data5, read_data6, read_data7, read_data8, read_data9,
      output res_ready,
      input  ret_ready, read_step, read_addr,
      input  res_valid, res_bndl, res_excpt, res_slot, res_code, res_aux,
      input  res_count, poll_cnt
   );
endinterface

// File: rtl/bob_except_scan.sv
// Retire-side scanner for the per-bundle exception record RAM (48 x 10 slots).
// Loads the RAM address for the requested bundle, polls the ten slot records
// until every enabled slot up to the first exception is complete, then holds
// one registered result until the retire logic accepts it.
module bob_except_scan #(
   parameter int DATA_WIDTH = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   bob_except_scan_if.slave  bus
);

   localparam int AUX_W = DATA_WIDTH - 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [5:0]       bndl_reg;
   logic [9:0]       mask_reg;
   logic [7:0]       poll_cnt_reg;

   logic [5:0]       res_bndl_reg;
   logic             res_excpt_reg;
   logic [3:0]       res_slot_reg;
   logic [4:0]       res_code_reg;
   logic [AUX_W-1:0] res_aux_reg;
   logic [3:0]       res_count_reg;

   logic             accept;
   logic             ret_ready_c;
   logic [5:0]       read_addr_c;

   // ------------------------------------------------------------------
   // Slot evaluation
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] slot_data [10];

   assign slot_data[0] = bus.read_data0;
   assign slot_data[1] = bus.read_data1;
   assign slot_data[2] = bus.read_data2;
   assign slot_data[3] = bus.read_data3;
   assign slot_data[4] = bus.read_data4;
   assign slot_data[5] = bus.read_data5;
   assign slot_data[6] = bus.read_data6;
   assign slot_data[7] = bus.read_data7;
   assign slot_data[8] = bus.read_data8;
   assign slot_data[9] = bus.read_data9;

   // exc_seen[i] is set when some enabled slot below i has excepted, so the
   // first excepting slot is the only one with slot_exc set and exc_seen clear.
   logic [10:0] exc_seen;
   logic [9:0]  slot_exc;
   logic [9:0]  slot_first;
   logic [9:0]  slot_below;
   logic [9:0]  slot_pend;
   logic        scan_ready;

   assign exc_seen[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_slot
         assign slot_exc[gi]     = mask_reg[gi] & slot_data[gi][1];
         assign exc_seen[gi+1]   = exc_seen[gi] | slot_exc[gi];
         assign slot_first[gi]   = slot_exc[gi] & ~exc_seen[gi];
         // enabled and strictly older than the first exception
         assign slot_below[gi]   = mask_reg[gi] & ~exc_seen[gi+1];
         // the excepting slot itself never holds the scan, whatever its done bit
         assign slot_pend[gi]    = slot_below[gi] & ~slot_data[gi][0];
      end
   endgenerate

   assign scan_ready = ~|slot_pend;

   logic [3:0]       first_slot;
   logic [4:0]       first_code;
   logic [AUX_W-1:0] first_aux;
   logic [3:0]       below_cnt;

   // Encode the first excepting slot and count the slots that will retire
   always_comb begin
      first_slot = 4'hF;
      first_code = 5'd0;
      first_aux  = '0;
      below_cnt  = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (slot_below[i]) begin
            below_cnt = below_cnt + 4'd1;
         end
         // at most one slot_first bit is ever set
         if (slot_first[i]) begin
            first_slot = 4'(i);
            first_code = slot_data[i][6:2];
            first_aux  = slot_data[i][DATA_WIDTH-1:7];
         end
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state, request handshake and RAM address drive
   always_comb begin
      state_next  = state_reg;
      ret_ready_c = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            ret_ready_c = 1'b1;
            if (bus.ret_valid) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (scan_ready) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            // a new request is only taken while the current result is being
            // retired, so ret_ready never promises an acceptance that is not made
            if (bus.res_ready) begin
               ret_ready_c = 1'b1;
               state_next  = bus.ret_valid ? ST_WAIT : ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (flush) begin
         ret_ready_c = 1'b0;
         state_next  = ST_IDLE;
      end
      if (rst) begin
         ret_ready_c = 1'b0;
      end

      accept = ret_ready_c & bus.ret_valid;

      // the RAM loads the address presented with read_step, so an accept
      // out of RESP must show the new bundle rather than the latched one
      if (rst) begin
         read_addr_c = 6'd0;
      end else if (state_reg == ST_IDLE || accept) begin
         read_addr_c = bus.ret_bndl;
      end else begin
         read_addr_c = bndl_reg;
      end
   end

   // Request latch and WAIT-cycle poll counter
   always_ff @(posedge clk) begin
      if (rst) begin
         bndl_reg     <= 6'd0;
         mask_reg     <= 10'd0;
         poll_cnt_reg <= 8'd0;
      end else if (accept) begin
         bndl_reg     <= bus.ret_bndl;
         mask_reg     <= bus.ret_mask;
         poll_cnt_reg <= 8'd0;
      end else if (state_reg == ST_WAIT && !scan_ready && !flush &&
                   poll_cnt_reg != 8'hFF) begin
         poll_cnt_reg <= poll_cnt_reg + 8'd1;
      end
   end

   // Result capture when the scan completes
   always_ff @(posedge clk) begin
      if (rst) begin
         res_bndl_reg  <= 6'd0;
         res_excpt_reg <= 1'b0;
         res_slot_reg  <= 4'hF;
         res_code_reg  <= 5'd0;
         res_aux_reg   <= '0;
         res_count_reg <= 4'd0;
      end else if (state_reg == ST_WAIT && scan_ready && !flush) begin
         res_bndl_reg  <= bndl_reg;
         res_excpt_reg <= exc_seen[10];
         res_slot_reg  <= first_slot;
         res_code_reg  <= first_code;
         res_aux_reg   <= first_aux;
         res_count_reg <= below_cnt;
      end
   end

   assign bus.ret_ready = ret_ready_c;
   assign bus.read_step = accept;
   assign bus.read_addr = read_addr_c;
   assign bus.res_valid = (state_reg == ST_RESP);
   assign bus.res_bndl  = res_bndl_reg;
   assign bus.res_excpt = res_excpt_reg;
   assign bus.res_slot  = res_slot_reg;
   assign bus.res_code  = res_code_reg;
   assign bus.res_aux   = res_aux_reg;
   assign bus.res_count = res_count_reg;
   assign bus.poll_cnt  = poll_cnt_reg;

endmodule
